// File: rtl/video_term_pkg.sv
// Shared video-terminal constants, character classification helpers and the
// cursor FSM state encoding.
package video_term_pkg;

    localparam int unsigned COLS   = 40;
    localparam int unsigned ROWS   = 24;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned ADDR_W = 10;

    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] PRINT_LO    = 7'h20;
    localparam logic [6:0] PRINT_HI    = 7'h5F;
    localparam logic [6:0] FOLD_LO     = 7'h60;
    localparam logic [6:0] FOLD_HI     = 7'h7E;
    localparam logic [6:0] FOLD_OFFSET = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITE       = 2'd1,
        ST_ADVANCE     = 2'd2,
        ST_SCROLL_WAIT = 2'd3
    } cursor_state_e;

    // Printable directly, or lower-case range that folds onto upper case.
    function automatic logic is_printable(input logic [6:0] code);
        return ((code >= PRINT_LO) && (code <= PRINT_HI)) ||
               ((code >= FOLD_LO)  && (code <= FOLD_HI));
    endfunction

    function automatic logic [5:0] fold_code(input logic [6:0] code);
        logic [6:0] folded;
        folded = (code >= FOLD_LO) ? (code - FOLD_OFFSET) : code;
        return folded[5:0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cursor_ctrl.sv
// Terminal cursor controller: accepts characters, writes them to screen memory,
// advances the cursor and requests a scroll when the bottom row overflows.
module cursor_ctrl #(
    parameter int unsigned COLS = video_term_pkg::COLS,
    parameter int unsigned ROWS = video_term_pkg::ROWS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       blink_in,
    input  logic       char_valid,
    input  logic [6:0] char_data,
    output logic       char_ready,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [5:0] wr_data,
    output logic       scroll_req,
    input  logic       scroll_done,
    output logic [5:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       cursor_on
);

    import video_term_pkg::*;

    cursor_state_e state, state_n;
    logic [5:0]    col_n;
    logic [4:0]    row_n;
    logic          newline, newline_n;
    logic          wr_en_n, scroll_req_n, char_ready_n, cursor_on_n;
    logic [9:0]    wr_addr_n;
    logic [5:0]    wr_data_n;
    logic          blink_sync;
    logic          accept;

    sync_2ff u_blink_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (blink_in),
        .q     (blink_sync)
    );

    assign accept = char_valid && char_ready;

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_n      = state;
        col_n        = cursor_col;
        row_n        = cursor_row;
        newline_n    = newline;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        scroll_req_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(char_data)) begin
                        state_n   = ST_WRITE;
                        newline_n = 1'b0;
                        wr_en_n   = 1'b1;
                        wr_addr_n = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);
                        wr_data_n = fold_code(char_data);
                    end else if (char_data == ASCII_CR) begin
                        state_n   = ST_ADVANCE;
                        newline_n = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                state_n = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                if (!newline && (cursor_col < COL_W'(COLS - 1))) begin
                    col_n   = cursor_col + 6'd1;
                    state_n = ST_IDLE;
                end else begin
                    col_n = '0;
                    // Bottom row stays put; the screen scrolls underneath it.
                    if (cursor_row < ROW_W'(ROWS - 1)) begin
                        row_n   = cursor_row + 5'd1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n      = ST_SCROLL_WAIT;
                        scroll_req_n = 1'b1;
                    end
                end
            end
            ST_SCROLL_WAIT: begin
                if (scroll_done) begin
                    state_n = ST_IDLE;
                end else begin
                    scroll_req_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        char_ready_n = (state_n == ST_IDLE);
        cursor_on_n  = blink_sync && (state_n == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cursor_col <= '0;
            cursor_row <= '0;
            newline    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            scroll_req <= 1'b0;
            char_ready <= 1'b0;
            cursor_on  <= 1'b0;
        end else begin
            state      <= state_n;
            cursor_col <= col_n;
            cursor_row <= row_n;
            newline    <= newline_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            scroll_req <= scroll_req_n;
            char_ready <= char_ready_n;
            cursor_on  <= cursor_on_n;
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: writes, folding, wrap, CR, scroll handshake,
// blink synchronization and reset abandonment.
module tb_cursor_ctrl;

    logic       clk;
    logic       rst_n;
    logic       blink_in;
    logic       char_valid;
    logic [6:0] char_data;
    logic       char_ready;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [5:0] wr_data;
    logic       scroll_req;
    logic       scroll_done;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       cursor_on;

    int checks = 0;
    int errors = 0;
    int exp_col;
    int exp_row;
    bit exp_scroll;
    int last_addr;

    cursor_ctrl #(.COLS(40), .ROWS(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blink_in    (blink_in),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .scroll_req  (scroll_req),
        .scroll_done (scroll_done),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .cursor_on   (cursor_on)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cursor reference: advance one cell, or newline when nl is set.
    task automatic model_advance(input bit nl);
        if (!nl && exp_col < 39) begin
            exp_col++;
        end else begin
            exp_col = 0;
            if (exp_row < 23) exp_row++;
            else exp_scroll = 1'b1;
        end
    endtask

    // Offer a code and return #1 after the edge that accepted it.
    task automatic send(input logic [6:0] c);
        int n;
        n = 0;
        char_valid = 1'b1;
        char_data  = c;
        while (char_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(n < 50), 32'd1);
        tick();
        char_valid = 1'b0;
    endtask

    task automatic put_char(input logic [6:0] c, input logic [5:0] data);
        int exp_addr;
        exp_addr = exp_row * 40 + exp_col;
        send(c);
        last_addr = int'(wr_addr);
        chk("wr_en_pulse", wr_en, 32'd1);
        chk("wr_addr", wr_addr, exp_addr);
        chk("wr_data", wr_data, data);
        chk("ready_in_write", char_ready, 32'd0);
        chk("cursor_off_write", cursor_on, 32'd0);
        chk("no_scroll_in_write", scroll_req, 32'd0);
        tick();
        chk("wr_en_drop", wr_en, 32'd0);
        chk("col_hold_advance", cursor_col, exp_col);
        tick();
        model_advance(1'b0);
        chk("col_after_char", cursor_col, exp_col);
        chk("row_after_char", cursor_row, exp_row);
        chk("scroll_after_char", scroll_req, exp_scroll);
        chk("ready_after_char", char_ready, !exp_scroll);
    endtask

    task automatic send_cr();
        send(7'h0D);
        chk("cr_ready_low", char_ready, 32'd0);
        chk("cr_no_write", wr_en, 32'd0);
        tick();
        model_advance(1'b1);
        chk("cr_col", cursor_col, exp_col);
        chk("cr_row", cursor_row, exp_row);
        chk("cr_scroll", scroll_req, exp_scroll);
        chk("cr_ready", char_ready, !exp_scroll);
    endtask

    task automatic send_ignored(input logic [6:0] c);
        send(c);
        chk("ign_ready", char_ready, 32'd1);
        chk("ign_no_write", wr_en, 32'd0);
        tick();
        chk("ign_no_write_late", wr_en, 32'd0);
        chk("ign_col", cursor_col, exp_col);
        chk("ign_row", cursor_row, exp_row);
    endtask

    initial begin
        rst_n       = 1'b1;
        blink_in    = 1'b0;
        char_valid  = 1'b0;
        char_data   = 7'h00;
        scroll_done = 1'b0;
        exp_col     = 0;
        exp_row     = 0;
        exp_scroll  = 1'b0;
        last_addr   = 0;

        // Reset state, visible before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", char_ready, 32'd0);
        chk("rst_wr_en", wr_en, 32'd0);
        chk("rst_scroll", scroll_req, 32'd0);
        chk("rst_col", cursor_col, 32'd0);
        chk("rst_row", cursor_row, 32'd0);
        chk("rst_cursor_on", cursor_on, 32'd0);
        tick();
        tick();
        chk("ready_held_in_reset", char_ready, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", char_ready, 32'd0);
        tick();
        chk("ready_first_edge", char_ready, 32'd1);

        // 'A' then 39 more printables fill row 0 and wrap.
        put_char(7'h41, 6'h01);
        for (int i = 1; i < 40; i++) begin
            logic [6:0] c;
            c = 7'h20 + 7'(i);
            put_char(c, (i < 32) ? 6'(32 + i) : 6'(i - 32));
        end
        chk("row0_last_addr", last_addr, 32'd39);
        chk("wrap_col", cursor_col, 32'd0);
        chk("wrap_row", cursor_row, 32'd1);

        // CR to row 2, move to col 5, then folded 'a'.
        send_cr();
        for (int i = 0; i < 5; i++) put_char(7'h42, 6'h02);
        put_char(7'h61, 6'h01);
        chk("fold_a_addr", last_addr, 32'd85);
        chk("fold_a_col", cursor_col, 32'd6);

        // Classification boundaries.
        put_char(7'h7E, 6'h1E);
        put_char(7'h5F, 6'h1F);
        put_char(7'h20, 6'h20);
        put_char(7'h60, 6'h00);
        send_ignored(7'h07);
        send_ignored(7'h1F);
        send_ignored(7'h7F);
        send_ignored(7'h00);

        // Stray scroll_done while idle changes nothing.
        scroll_done = 1'b1;
        tick();
        scroll_done = 1'b0;
        chk("stray_done_scroll", scroll_req, 32'd0);
        chk("stray_done_ready", char_ready, 32'd1);
        chk("stray_done_col", cursor_col, 32'd10);

        // Blink follows through the synchronizer; suppressed outside IDLE.
        blink_in = 1'b1;
        tick();
        chk("blink_not_yet", cursor_on, 32'd0);
        tick();
        tick();
        chk("blink_on", cursor_on, 32'd1);
        put_char(7'h5A, 6'h1A);
        chk("blink_on_after_write", cursor_on, 32'd1);
        blink_in = 1'b0;
        tick();
        chk("blink_still_on", cursor_on, 32'd1);
        tick();
        tick();
        chk("blink_off", cursor_on, 32'd0);

        // Walk down to row 23, then CR there forces a scroll.
        for (int i = 0; i < 21; i++) send_cr();
        chk("at_bottom_row", cursor_row, 32'd23);
        send_cr();
        chk("cr_scroll_req", scroll_req, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("scroll_wait_req", scroll_req, 32'd1);
            chk("scroll_wait_ready", char_ready, 32'd0);
            chk("scroll_wait_no_wr", wr_en, 32'd0);
        end
        scroll_done = 1'b1;
        tick();
        scroll_done = 1'b0;
        exp_scroll = 1'b0;
        chk("scroll_done_req", scroll_req, 32'd0);
        chk("scroll_done_ready", char_ready, 32'd1);
        chk("scroll_done_row", cursor_row, 32'd23);
        chk("scroll_done_col", cursor_col, 32'd0);

        // Fill bottom row; last cell is the highest address, then scroll.
        for (int i = 0; i < 39; i++) put_char(7'h58, 6'h18);
        put_char(7'h59, 6'h19);
        chk("max_addr", last_addr, 32'd959);
        tick();
        tick();
        chk("wrap_scroll_req", scroll_req, 32'd1);

        // Reset during SCROLL_WAIT abandons the scroll.
        rst_n = 1'b0;
        #1;
        chk("rst_scroll_req", scroll_req, 32'd0);
        chk("rst_scroll_row", cursor_row, 32'd0);
        chk("rst_scroll_col", cursor_col, 32'd0);
        chk("rst_scroll_ready", char_ready, 32'd0);
        exp_col = 0;
        exp_row = 0;
        exp_scroll = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_no_scroll", scroll_req, 32'd0);
            chk("post_rst_no_wr", wr_en, 32'd0);
        end
        chk("post_rst_ready", char_ready, 32'd1);

        // Reset during WRITE abandons the write.
        send(7'h42);
        chk("mid_write_wr_en", wr_en, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_write_rst_wr_en", wr_en, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("after_write_rst_no_wr", wr_en, 32'd0);
            chk("after_write_rst_col", cursor_col, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 Parameter COLS, default 40: characters per row.
REQ-002 Parameter ROWS, default 24: rows per screen.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 blink_in  input  1  cursor blink square wave from the 555-timer block; treated as asynchronous.
REQ-006 char_valid  input  1  producer offers a character.
REQ-007 char_data  input  7  offered ASCII code.
REQ-008 char_ready  output  1  block accepts char_data this cycle.
REQ-009 wr_en  output  1  one-cycle write strobe to screen memory.
REQ-010 wr_addr  output  10  screen cell address, row*COLS+col.
REQ-011 wr_data  output  6  character code written, ASCII bits [5:0].
REQ-012 scroll_req  output  1  request that the screen scroll up one row.
REQ-013 scroll_done  input  1  one-cycle pulse: scroll finished.
REQ-014 cursor_col  output  6  current cursor column, 0..COLS-1.
REQ-015 cursor_row  output  5  current cursor row, 0..ROWS-1.
REQ-016 cursor_on  output  1  cursor glyph visible this cycle.

Function
REQ-017 Handshake: a character transfers on a clock edge where char_valid and char_ready are both 1; char_ready SHALL be 1 only in IDLE.
REQ-018 FSM states: IDLE, WRITE, ADVANCE, SCROLL_WAIT.
REQ-019 Classification, IDLE accept:
- 0x20..0x5F printable -> WRITE.
- 0x60..0x7E folded to code-0x20, then printable -> WRITE.
- 0x0D (CR) -> ADVANCE with newline flag.
- All other codes consumed, no effect, stay IDLE.
REQ-020 WRITE (one cycle): wr_en=1, wr_addr=cursor_row*COLS+cursor_col, wr_data=folded code [5:0]; next ADVANCE.
REQ-021 ADVANCE, printable, col<COLS-1: col+1, next IDLE.
REQ-022 ADVANCE, printable with col=COLS-1, or CR: col<=0; if row<ROWS-1 then row+1, next IDLE; else row holds ROWS-1, next SCROLL_WAIT.
REQ-023 SCROLL_WAIT: scroll_req=1 until the cycle scroll_done=1 is sampled, then IDLE with scroll_req=0 on the next cycle.
REQ-024 scroll_done outside SCROLL_WAIT SHALL be ignored.
REQ-025 Latency: accept at edge N -> wr_en high in cycle N+1 -> position updated and char_ready=1 at N+2 (no scroll).
REQ-026 CR latency: accept at N -> position updated at N+1, char_ready=1 at N+1 (no scroll).
REQ-027 blink_in SHALL pass a two-flop synchronizer; cursor_on = synchronized blink AND (state==IDLE).
REQ-028 cursor_on reacts to blink_in within 2-3 clk cycles.
REQ-029 wr_addr arithmetic SHALL be 10-bit unsigned, maximum (ROWS*COLS-1)=959, never wraps.
REQ-030 wr_en, scroll_req SHALL never be high simultaneously.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, cursor_col=0, cursor_row=0, wr_en=0, scroll_req=0, synchronizer flops 0, cursor_on=0, char_ready=0.
REQ-032 char_ready SHALL go 1 on the first clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-WRITE or mid-SCROLL_WAIT SHALL abandon the operation; no write or scroll request after release.

Structure
REQ-034 Shared package video_term_pkg: COLS, ROWS, ASCII_CR, fold/printable range constants, cursor FSM state encoding.
REQ-035 Blink synchronizer SHALL be the reusable sub-module sync_2ff.

Verification
REQ-036 Reset, then send 'A'(0x41) -> wr_en one cycle, wr_addr=0, wr_data=0x01; cursor_col=1 two cycles after accept.
REQ-037 Send 'a'(0x61) at col 5, row 2 -> wr_addr=85, wr_data=0x01; col=6.
REQ-038 40 printable chars from (0,0) -> last at wr_addr=39; cursor (col 0,row 1).
REQ-039 At row 23 send CR -> scroll_req high, char_ready low; pulse scroll_done after 10 cycles -> scroll_req low, row=23, col=0, char_ready=1.
REQ-040 Toggle blink_in while IDLE -> cursor_on follows in 2-3 cycles; during WRITE cursor_on=0; send 0x07 -> no wr_en, position unchanged.
REQ-041 Assert rst_n low during SCROLL_WAIT -> scroll_req, cursor_row, cursor_col all 0 immediately; no later scroll_req.
